// File: rtl/snn_core_param.sv
`default_nettype none
// ============================================================================
// Module   : snn_core_param
// Brief    : Parametrised two-layer spiking-style inference core
//            (binary image -> hidden layer -> output layer, argmax readout).
// Revision : 1.0
// ============================================================================
module snn_core_param #(
    parameter int N_IN   = 784,
    parameter int N_HID  = 32,
    parameter int N_OUT  = 10,
    parameter int W      = 8,
    parameter int FRAC   = 7,
    parameter int LUT_AW = 11,
    localparam int IN_AW  = $clog2(N_IN),
    localparam int WA_W   = $clog2(N_HID*N_IN + N_OUT*N_HID),
    localparam int OUT_AW = $clog2(N_OUT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic              abort_i,
    output logic              ready_o,
    output logic [IN_AW-1:0]  in_addr_o,
    input  logic              in_bit_i,
    output logic [WA_W-1:0]   w_addr_o,
    input  logic [W-1:0]      w_data_i,
    output logic [LUT_AW-1:0] lut_addr_o,
    input  logic [W-1:0]      lut_data_i,
    output logic              done_o,
    output logic [OUT_AW-1:0] digit_o,
    output logic [W-1:0]      max_val_o
);

    localparam int HID_AW = (N_HID > 1) ? $clog2(N_HID) : 1;
    localparam int MAXD   = (N_IN > N_HID) ? N_IN : N_HID;
    localparam int ACC_W  = 2*W + $clog2(MAXD) + 1;
    localparam int XW     = (ACC_W > FRAC + LUT_AW) ? ACC_W : FRAC + LUT_AW + 1;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_H_MAC   = 4'd1;
    localparam logic [3:0] S_H_DRAIN = 4'd2;
    localparam logic [3:0] S_H_LUT   = 4'd3;
    localparam logic [3:0] S_H_WR    = 4'd4;
    localparam logic [3:0] S_O_MAC   = 4'd5;
    localparam logic [3:0] S_O_DRAIN = 4'd6;
    localparam logic [3:0] S_O_LUT   = 4'd7;
    localparam logic [3:0] S_O_WR    = 4'd8;
    localparam logic [3:0] S_DONE    = 4'd9;

    localparam logic [IN_AW-1:0]  IN_LAST  = IN_AW'(N_IN - 1);
    localparam logic [HID_AW-1:0] HID_LAST = HID_AW'(N_HID - 1);
    localparam logic [OUT_AW-1:0] OUT_LAST = OUT_AW'(N_OUT - 1);
    localparam logic [W-1:0]      ONE_EXT  = W'((1 << (W-1)) - 1);

    logic [3:0]              state_q, state_d;
    logic [IN_AW-1:0]        i_q, i_d;
    logic [HID_AW-1:0]       j_q, j_d;
    logic [OUT_AW-1:0]       k_q, k_d;
    logic [WA_W-1:0]         waddr_q, waddr_d;
    logic [OUT_AW-1:0]       digit_q, digit_d;
    logic [W-1:0]            maxv_q, maxv_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [W-1:0]            hid_q [N_HID];
    logic [W-1:0]            hid_rd_q;
    logic                    vld_q;
    logic                    hph_q;
    logic                    done_q;

    logic                    w_acc_clr;
    logic                    w_hid_we;
    logic                    w_acc_en;
    logic signed [W-1:0]     w_op_a;
    logic signed [2*W-1:0]   w_prod;
    logic signed [XW-1:0]    w_acc_x;
    logic [XW-FRAC-LUT_AW:0] w_hi;
    logic [LUT_AW-1:0]       w_sat;
    logic                    w_unused_lo;

    // Control: counters and transitions; abort overrides everything but rst.
    always_comb begin
        state_d   = state_q;
        i_d       = i_q;
        j_d       = j_q;
        k_d       = k_q;
        waddr_d   = waddr_q;
        digit_d   = digit_q;
        maxv_d    = maxv_q;
        w_acc_clr = 1'b0;
        w_hid_we  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    state_d   = S_H_MAC;
                    i_d       = '0;
                    j_d       = '0;
                    k_d       = '0;
                    waddr_d   = '0;
                    digit_d   = '0;
                    maxv_d    = '0;
                    w_acc_clr = 1'b1;
                end
            end
            S_H_MAC: begin
                waddr_d = waddr_q + WA_W'(1);
                if (i_q == IN_LAST) begin
                    i_d     = '0;
                    state_d = S_H_DRAIN;
                end else begin
                    i_d = i_q + IN_AW'(1);
                end
            end
            S_H_DRAIN: state_d = S_H_LUT;
            S_H_LUT:   state_d = S_H_WR;
            S_H_WR: begin
                w_hid_we  = 1'b1;
                w_acc_clr = 1'b1;
                if (j_q == HID_LAST) begin
                    j_d     = '0;
                    k_d     = '0;
                    state_d = S_O_MAC;
                end else begin
                    j_d     = j_q + HID_AW'(1);
                    state_d = S_H_MAC;
                end
            end
            S_O_MAC: begin
                // The very last weight address is not stepped past, so
                // w_addr never leaves the ROM range.
                if (!(j_q == HID_LAST && k_q == OUT_LAST)) begin
                    waddr_d = waddr_q + WA_W'(1);
                end
                if (j_q == HID_LAST) begin
                    j_d     = '0;
                    state_d = S_O_DRAIN;
                end else begin
                    j_d = j_q + HID_AW'(1);
                end
            end
            S_O_DRAIN: state_d = S_O_LUT;
            S_O_LUT:   state_d = S_O_WR;
            S_O_WR: begin
                if (k_q == '0 || lut_data_i > maxv_q) begin
                    maxv_d  = lut_data_i;
                    digit_d = k_q;
                end
                if (k_q == OUT_LAST) begin
                    state_d = S_DONE;
                end else begin
                    k_d       = k_q + OUT_AW'(1);
                    w_acc_clr = 1'b1;
                    state_d   = S_O_MAC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort_i && state_q != S_IDLE) begin
            state_d   = S_IDLE;
            i_d       = '0;
            j_d       = '0;
            k_d       = '0;
            waddr_d   = '0;
            digit_d   = digit_q;
            maxv_d    = maxv_q;
            w_acc_clr = 1'b0;
            w_hid_we  = 1'b0;
        end
    end

    // Memory data arrives one cycle after its address, so products are
    // accumulated in the cycle following an address-issuing MAC cycle.
    always_comb begin
        w_op_a   = hph_q ? (in_bit_i ? ONE_EXT : '0) : hid_rd_q;
        w_prod   = (2*W)'(w_op_a) * (2*W)'($signed(w_data_i));
        w_acc_en = vld_q && (state_q == S_H_MAC || state_q == S_H_DRAIN ||
                             state_q == S_O_MAC || state_q == S_O_DRAIN);
        if (w_acc_clr) begin
            acc_d = '0;
        end else if (w_acc_en) begin
            acc_d = acc_q + ACC_W'(w_prod);
        end else begin
            acc_d = acc_q;
        end
    end

    always_comb begin
        w_acc_x = XW'(acc_q);
        w_hi    = w_acc_x[XW-1:FRAC+LUT_AW-1];
        if (&w_hi || ~|w_hi) begin
            w_sat = w_acc_x[FRAC+LUT_AW-1:FRAC];
        end else if (w_acc_x[XW-1]) begin
            w_sat = {1'b1, {(LUT_AW-1){1'b0}}};
        end else begin
            w_sat = {1'b0, {(LUT_AW-1){1'b1}}};
        end
    end

    assign w_unused_lo = ^w_acc_x[FRAC-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            waddr_q <= '0;
            digit_q <= '0;
            maxv_q  <= '0;
            acc_q   <= '0;
            vld_q   <= 1'b0;
            hph_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            waddr_q <= waddr_d;
            digit_q <= digit_d;
            maxv_q  <= maxv_d;
            acc_q   <= acc_d;
            vld_q   <= (state_q == S_H_MAC || state_q == S_O_MAC) && !abort_i;
            hph_q   <= (state_q == S_H_MAC);
            done_q  <= (state_q == S_DONE) && !abort_i;
        end
    end

    // Hidden activation store needs no reset; its contents are rewritten
    // before every read.
    always_ff @(posedge clk) begin
        if (w_hid_we) begin
            hid_q[j_q] <= lut_data_i;
        end
        hid_rd_q <= hid_q[j_q];
    end

    assign ready_o    = (state_q == S_IDLE);
    assign in_addr_o  = i_q;
    assign w_addr_o   = waddr_q;
    assign lut_addr_o = {~w_sat[LUT_AW-1], w_sat[LUT_AW-2:0]};
    assign done_o     = done_q;
    assign digit_o    = digit_q;
    assign max_val_o  = maxv_q;

endmodule
`default_nettype wire

// File: tb/tb_snn_core_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_snn_core_param
// Brief    : Scoreboard bench for snn_core_param (small and default configs).
// Revision : 1.0
// ============================================================================
module tb_snn_core_param;

    localparam int A_IN  = 4;
    localparam int A_HID = 2;
    localparam int A_OUT = 3;
    localparam int A_WN  = A_HID*A_IN + A_OUT*A_HID;
    localparam int B_IN  = 784;
    localparam int B_HID = 32;
    localparam int B_OUT = 10;
    localparam int B_WN  = B_HID*B_IN + B_OUT*B_HID;

    typedef struct { int dig; int mx; int lat; } res_t;
    typedef struct { int cyc; int addr; } lchk_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_start, a_abort, a_ready, a_in_bit, a_done;
    logic [1:0]  a_in_addr;
    logic [3:0]  a_w_addr;
    logic [7:0]  a_w_data, a_lut_data, a_max;
    logic [10:0] a_lut_addr;
    logic [1:0]  a_digit;

    logic        b_start, b_abort, b_ready, b_in_bit, b_done;
    logic [9:0]  b_in_addr;
    logic [14:0] b_w_addr;
    logic [7:0]  b_w_data, b_lut_data, b_max;
    logic [10:0] b_lut_addr;
    logic [3:0]  b_digit;

    bit                img [B_IN];
    logic signed [7:0] wts [B_WN];
    logic [7:0]        lut [2048];

    res_t  sb_q [$];
    lchk_t lut_q [$];
    int    n_chk = 0;
    int    n_err = 0;
    bit    cur = 1'b0;

    logic        m_done, m_ready;
    logic [10:0] m_lut;
    int          m_digit, m_max;

    snn_core_param #(.N_IN(A_IN), .N_HID(A_HID), .N_OUT(A_OUT)) u_dut_a (
        .clk(clk), .rst(rst), .start_i(a_start), .abort_i(a_abort), .ready_o(a_ready),
        .in_addr_o(a_in_addr), .in_bit_i(a_in_bit), .w_addr_o(a_w_addr), .w_data_i(a_w_data),
        .lut_addr_o(a_lut_addr), .lut_data_i(a_lut_data), .done_o(a_done),
        .digit_o(a_digit), .max_val_o(a_max)
    );

    snn_core_param u_dut_b (
        .clk(clk), .rst(rst), .start_i(b_start), .abort_i(b_abort), .ready_o(b_ready),
        .in_addr_o(b_in_addr), .in_bit_i(b_in_bit), .w_addr_o(b_w_addr), .w_data_i(b_w_data),
        .lut_addr_o(b_lut_addr), .lut_data_i(b_lut_data), .done_o(b_done),
        .digit_o(b_digit), .max_val_o(b_max)
    );

    // External memories with one cycle of read latency.
    always @(posedge clk) begin
        a_in_bit   <= img[int'(a_in_addr)];
        a_w_data   <= wts[int'(a_w_addr)];
        a_lut_data <= lut[int'(a_lut_addr)];
        b_in_bit   <= img[int'(b_in_addr)];
        b_w_data   <= wts[int'(b_w_addr)];
        b_lut_data <= lut[int'(b_lut_addr)];
    end

    always_comb begin
        m_done  = cur ? b_done     : a_done;
        m_ready = cur ? b_ready    : a_ready;
        m_lut   = cur ? b_lut_addr : a_lut_addr;
        m_digit = cur ? int'(b_digit) : int'(a_digit);
        m_max   = cur ? int'(b_max)   : int'(a_max);
    end

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic set_start(input bit v);
        if (cur) b_start = v; else a_start = v;
    endtask

    task automatic set_abort(input bit v);
        if (cur) b_abort = v; else a_abort = v;
    endtask

    function automatic int rect(input longint acc);
        longint s;
        s = acc >>> 7;
        if (s > 1023)  s = 1023;
        if (s < -1024) s = -1024;
        return int'(s) + 1024;
    endfunction

    // Reference network; also queues the expected LUT address at each
    // LUT-lookup cycle (offset from the start-sampling edge).
    task automatic model(input int nin, input int nhid, input int nout,
                         output int dig, output int mx);
        int     hid [B_HID];
        longint acc;
        int     la, o, base;
        base = nhid*(nin+3);
        dig  = 0;
        mx   = 0;
        for (int j = 0; j < nhid; j++) begin
            acc = 0;
            for (int i = 0; i < nin; i++)
                if (img[i]) acc += 127 * longint'(wts[j*nin + i]);
            la = rect(acc);
            lut_q.push_back('{j*(nin+3) + nin + 1, la});
            hid[j] = int'($signed(lut[la]));
        end
        for (int k = 0; k < nout; k++) begin
            acc = 0;
            for (int j = 0; j < nhid; j++)
                acc += longint'(hid[j]) * longint'(wts[nhid*nin + k*nhid + j]);
            la = rect(acc);
            lut_q.push_back('{base + k*(nhid+3) + nhid + 1, la});
            o = int'(lut[la]);
            if (k == 0 || o > mx) begin
                mx  = o;
                dig = k;
            end
        end
    endtask

    task automatic run_one(input bit sel, input int nin, input int nhid, input int nout,
                           input int poke);
        int    dig, mx, lat, c;
        bit    seen;
        res_t  e;
        lchk_t l;
        cur = sel;
        model(nin, nhid, nout, dig, mx);
        lat = nhid*(nin+3) + nout*(nhid+3) + 1;
        sb_q.push_back('{dig, mx, lat});
        @(negedge clk);
        set_start(1'b1);
        @(posedge clk); #1;
        set_start(1'b0);
        check_eq("ready_busy", m_ready, 0);
        c    = 0;
        seen = 1'b0;
        while (!seen && c <= lat + 20) begin
            if (lut_q.size() > 0 && lut_q[0].cyc == c) begin
                l = lut_q.pop_front();
                check_eq("lut_addr", m_lut, l.addr);
            end
            set_start(c == poke);
            if (m_done) begin
                seen = 1'b1;
                e = sb_q.pop_front();
                check_eq("latency", c, e.lat);
                check_eq("digit", m_digit, e.dig);
                check_eq("max_val", m_max, e.mx);
                check_eq("ready_at_done", m_ready, 1);
            end else begin
                @(posedge clk); #1;
                c++;
            end
        end
        set_start(1'b0);
        if (!seen) begin
            check_eq("done_timeout", 0, 1);
            sb_q.delete();
        end
        check_eq("lut_pending", lut_q.size(), 0);
        lut_q.delete();
        @(posedge clk); #1;
        check_eq("done_single", m_done, 0);
        check_eq("digit_hold", m_digit, dig);
        check_eq("max_hold", m_max, mx);
    endtask

    task automatic load_fixed_a();
        for (int i = 0; i < A_IN; i++) img[i] = 1'b1;
        for (int x = 0; x < A_HID*A_IN; x++) wts[x] = 8'sd1;
        wts[8]  = 8'sd1;  wts[9]  = 8'sd1;
        wts[10] = 8'sd2;  wts[11] = 8'sd2;
        wts[12] = -8'sd1; wts[13] = -8'sd1;
        for (int a = 0; a < 2048; a++) lut[a] = 8'(a >> 3);
        lut[1022] = 8'd5;
        lut[1020] = 8'd9;
        lut[1026] = 8'd9;
    endtask

    initial begin
        int cnt;
        rst = 1'b1;
        a_start = 1'b0; a_abort = 1'b0;
        b_start = 1'b0; b_abort = 1'b0;
        for (int a = 0; a < 2048; a++) lut[a] = 8'(a >> 3);
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ready", a_ready, 1);
        check_eq("rst_done", a_done, 0);
        check_eq("rst_digit", a_digit, 0);
        check_eq("rst_max", a_max, 0);
        check_eq("rst_in_addr", a_in_addr, 0);
        check_eq("rst_w_addr", a_w_addr, 0);
        check_eq("rst_lut_addr", a_lut_addr, 1024);
        check_eq("rst_b_ready", b_ready, 1);
        check_eq("rst_b_lut_addr", b_lut_addr, 1024);
        @(negedge clk);
        rst = 1'b0;

        // Small config, tie between k=1 and k=2, stray start mid-run.
        load_fixed_a();
        run_one(1'b0, A_IN, A_HID, A_OUT, 10);

        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < A_IN; i++) img[i] = bit'($urandom_range(0, 1));
            for (int x = 0; x < A_WN; x++) wts[x] = 8'($urandom_range(0, 255));
            for (int a = 0; a < 2048; a++) lut[a] = 8'($urandom_range(0, 255));
            run_one(1'b0, A_IN, A_HID, A_OUT, -1);
        end

        // Abort in H_MAC, then start and abort together in IDLE.
        cur = 1'b0;
        @(negedge clk); set_start(1'b1);
        @(posedge clk); #1; set_start(1'b0);
        repeat (2) begin @(posedge clk); #1; end
        set_abort(1'b1);
        @(posedge clk); #1;
        set_abort(1'b0);
        check_eq("abort_ready", m_ready, 1);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (m_done) cnt++;
        end
        check_eq("abort_no_done", cnt, 0);
        set_start(1'b1); set_abort(1'b1);
        @(posedge clk); #1;
        set_start(1'b0); set_abort(1'b0);
        check_eq("abort_beats_start", m_ready, 1);
        run_one(1'b0, A_IN, A_HID, A_OUT, -1);

        // Reset during O_MAC of the second output neuron.
        load_fixed_a();
        @(negedge clk); set_start(1'b1);
        @(posedge clk); #1; set_start(1'b0);
        repeat (20) begin @(posedge clk); #1; end
        check_eq("max_before_rst", m_max, 5);
        check_eq("ready_before_rst", m_ready, 0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_eq("mid_rst_ready", m_ready, 1);
        check_eq("mid_rst_digit", m_digit, 0);
        check_eq("mid_rst_max", m_max, 0);
        check_eq("mid_rst_done", m_done, 0);
        check_eq("mid_rst_lut_addr", m_lut, 1024);
        check_eq("mid_rst_w_addr", a_w_addr, 0);

        // Default dimensions: positive/negative saturation, in-range, zero.
        for (int i = 0; i < B_IN; i++) img[i] = 1'b1;
        for (int j = 0; j < B_HID; j++)
            for (int i = 0; i < B_IN; i++)
                case (j % 4)
                    0:       wts[j*B_IN + i] = 8'sd127;
                    1:       wts[j*B_IN + i] = -8'sd128;
                    2:       wts[j*B_IN + i] = 8'sd1;
                    default: wts[j*B_IN + i] = 8'sd0;
                endcase
        for (int k = 0; k < B_OUT; k++)
            for (int j = 0; j < B_HID; j++)
                wts[B_HID*B_IN + k*B_HID + j] = 8'(((k*7 + j*3) % 11) - 5);
        for (int a = 0; a < 2048; a++) lut[a] = 8'(a >> 3);
        run_one(1'b1, B_IN, B_HID, B_OUT, -1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
